// File: rtl/m68k_bus_initiator.sv
// 68000 bus initiator: request handshake in, full AS/DS/DTACK cycle out.
// Optional WAIT-state timeout is enabled by defining BUS_TIMEOUT_EN.
module m68k_bus_initiator #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        GRANT,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [22:0] REQ_A,
  input  logic        REQ_UDS,
  input  logic        REQ_LDS,
  input  logic [15:0] REQ_WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [15:0] RDATA,
  output logic        BUSY,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [22:0] A,
  output logic [15:0] D_OUT,
  output logic        D_OE,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic [15:0] D_IN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STRB,
    S_DS,
    S_WAIT,
    S_LATCH,
    S_NEG,
    S_REC
  } state_e;

  if (TIMEOUT >= (1 << CW)) begin : g_cw_check
    $error("CW too narrow for TIMEOUT");
  end

  state_e      state_q;
  logic        dtack_s1_q;
  logic        dtack_s_q;
  logic        berr_s1_q;
  logic        berr_s_q;
  logic        dtack_s;
  logic        berr_s;

  logic        lat_rw_q;
  logic [22:0] lat_a_q;
  logic        lat_uds_q;
  logic        lat_lds_q;
  logic [15:0] lat_wd_q;
  logic        errf_q;

  logic        ack_q;
  logic        err_q;
  logic [15:0] rdata_q;
  logic        busy_q;
  logic        as_q;
  logic        uds_q;
  logic        lds_q;
  logic        rw_q;
  logic [22:0] a_q;
  logic [15:0] dout_q;
  logic        doe_q;

`ifdef BUS_TIMEOUT_EN
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  assign cnt_d = cnt_q + 1'b1;
`endif

  // Responses are asynchronous to CLK; resolve them before the FSM sees them
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dtack_s1_q <= 1'b1;
      dtack_s_q  <= 1'b1;
      berr_s1_q  <= 1'b1;
      berr_s_q   <= 1'b1;
    end else begin
      dtack_s1_q <= DTACK;
      dtack_s_q  <= dtack_s1_q;
      berr_s1_q  <= BERR;
      berr_s_q   <= berr_s1_q;
    end
  end

  assign dtack_s = dtack_s_q;
  assign berr_s  = berr_s_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      lat_rw_q  <= 1'b1;
      lat_a_q   <= '0;
      lat_uds_q <= 1'b1;
      lat_lds_q <= 1'b1;
      lat_wd_q  <= '0;
      errf_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
      as_q      <= 1'b1;
      uds_q     <= 1'b1;
      lds_q     <= 1'b1;
      rw_q      <= 1'b1;
      a_q       <= '0;
      dout_q    <= '0;
      doe_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (REQ && GRANT) begin
            lat_rw_q  <= REQ_RW;
            lat_a_q   <= REQ_A;
            lat_uds_q <= REQ_UDS;
            lat_lds_q <= REQ_LDS;
            lat_wd_q  <= REQ_WDATA;
            errf_q    <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          a_q  <= lat_a_q;
          rw_q <= lat_rw_q;
          if (!lat_rw_q) begin
            dout_q <= lat_wd_q;
            doe_q  <= 1'b1;
          end
          state_q <= S_STRB;
        end
        S_STRB: begin
          as_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
          cnt_q <= '0;
`endif
          // Reads assert DS with AS; writes give data a state to settle
          if (lat_rw_q) begin
            uds_q   <= lat_uds_q;
            lds_q   <= lat_lds_q;
            state_q <= S_WAIT;
          end else begin
            state_q <= S_DS;
          end
        end
        S_DS: begin
          uds_q   <= lat_uds_q;
          lds_q   <= lat_lds_q;
`ifdef BUS_TIMEOUT_EN
          cnt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!berr_s) begin
            errf_q  <= 1'b1;
            state_q <= S_NEG;
          end else if (!dtack_s) begin
            state_q <= S_LATCH;
`ifdef BUS_TIMEOUT_EN
          end else if (cnt_d == CW'(TIMEOUT)) begin
            errf_q  <= 1'b1;
            state_q <= S_NEG;
          end else begin
            cnt_q <= cnt_d;
`endif
          end
        end
        S_LATCH: begin
          if (lat_rw_q) begin
            rdata_q <= D_IN;
          end
          state_q <= S_NEG;
        end
        S_NEG: begin
          as_q    <= 1'b1;
          uds_q   <= 1'b1;
          lds_q   <= 1'b1;
          ack_q   <= !errf_q;
          err_q   <= errf_q;
          state_q <= S_REC;
        end
        S_REC: begin
          doe_q <= 1'b0;
          rw_q  <= 1'b1;
          // Hold off until the responder has released both lines
          if (dtack_s && berr_s) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy_q;
  assign AS    = as_q;
  assign UDS   = uds_q;
  assign LDS   = lds_q;
  assign RW    = rw_q;
  assign A     = a_q;
  assign D_OUT = dout_q;
  assign D_OE  = doe_q;

endmodule
